// File: rtl/i2c_write_sequencer.sv
// i2c_write_sequencer
// Drives a register-mapped I2C master core (PRER lo/hi, CTR, TXR, CR/SR) to
// perform single-byte register writes: START+dev/W, reg index, data+STOP.
// After reset the prescaler and core enable are programmed once.
//
// Controller handshake: every access is a one-cycle ctl_start strobe with
// ctl_addr/ctl_din/ctl_wren valid on that cycle and held until ctl_done;
// ctl_done is only honoured while an access is outstanding.  Request side:
// a request is taken on the cycle req_valid && req_ready.
//
// Optional feature: define I2C_SEQ_TIMEOUT_EN to bound each status-poll loop
// to TIMEOUT_POLLS reads; on expiry the transfer is aborted with a STOP and
// flagged via nack.
module i2c_write_sequencer #(
    parameter logic [15:0] PRESCALE      = 16'h0020,
    parameter int          TIMEOUT_POLLS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [6:0]  req_dev,
    input  logic [7:0]  req_reg,
    input  logic [7:0]  req_data,
    output logic [31:0] ctl_din,
    output logic [31:0] ctl_addr,
    output logic        ctl_start,
    output logic        ctl_wren,
    input  logic [31:0] ctl_dout,
    input  logic        ctl_done,
    output logic        done,
    output logic        nack,
    output logic [3:0]  dbg_state
);

    typedef enum logic [3:0] {
        INIT_PRL  = 4'd0,
        INIT_PRH  = 4'd1,
        INIT_CTR  = 4'd2,
        IDLE      = 4'd3,
        LD_TXR    = 4'd4,
        WR_CR     = 4'd5,
        POLL      = 4'd6,
        CHECK     = 4'd7,
        STOP_CR   = 4'd8,
        STOP_POLL = 4'd9,
        FINISH    = 4'd10
    } state_t;

    state_t      state_q, state_d;
    logic        wait_q, wait_d;      // 0 = issue sub-phase, 1 = waiting for ctl_done
    logic [1:0]  phase_q, phase_d;    // byte phase 0..2
    logic [6:0]  dev_q, dev_d;
    logic [7:0]  reg_q, reg_d;
    logic [7:0]  data_q, data_d;
    logic        nack_q, nack_d;
    logic        rxack_q, rxack_d;
    logic        start_q, start_d;
    logic        wren_q, wren_d;
    logic [2:0]  addr_q, addr_d;
    logic [7:0]  din_q, din_d;

    // Access description for the current state.
    logic        acc_en;
    logic        acc_wren;
    logic [2:0]  acc_addr;
    logic [7:0]  acc_din;
    logic        acc_complete;
    logic [7:0]  txr_val;
    logic [7:0]  cr_val;

`ifdef I2C_SEQ_TIMEOUT_EN
    localparam logic [31:0] POLL_LIMIT = TIMEOUT_POLLS;
    logic [31:0] poll_cnt_q, poll_cnt_d;
    logic        abort_q, abort_d;    // timeout abort: skip the STOP poll
    logic        poll_expired;
`else
    localparam int unused_timeout_polls = TIMEOUT_POLLS;
`endif

    // Only TIP and RxACK of the status register are meaningful here.
    logic unused_dout;
    assign unused_dout = ^{ctl_dout[31:8], ctl_dout[6:2], ctl_dout[0]};

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= INIT_PRL;
            wait_q  <= 1'b0;
            phase_q <= 2'd0;
            dev_q   <= 7'd0;
            reg_q   <= 8'd0;
            data_q  <= 8'd0;
            nack_q  <= 1'b0;
            rxack_q <= 1'b0;
            start_q <= 1'b0;
            wren_q  <= 1'b0;
            addr_q  <= 3'd0;
            din_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            phase_q <= phase_d;
            dev_q   <= dev_d;
            reg_q   <= reg_d;
            data_q  <= data_d;
            nack_q  <= nack_d;
            rxack_q <= rxack_d;
            start_q <= start_d;
            wren_q  <= wren_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
        end
    end

`ifdef I2C_SEQ_TIMEOUT_EN
    // Poll-loop counter and abort flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            poll_cnt_q <= 32'd0;
            abort_q    <= 1'b0;
        end else begin
            poll_cnt_q <= poll_cnt_d;
            abort_q    <= abort_d;
        end
    end
`endif

    // Byte values for the current phase.
    always_comb begin
        txr_val = data_q;
        cr_val  = 8'h50;
        case (phase_q)
            2'd0: begin
                txr_val = {dev_q, 1'b0};
                cr_val  = 8'h90;
            end
            2'd1: begin
                txr_val = reg_q;
                cr_val  = 8'h10;
            end
            default: ;
        endcase
    end

    // Next-state, access issue/wait and request capture.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        phase_d = phase_q;
        dev_d   = dev_q;
        reg_d   = reg_q;
        data_d  = data_q;
        nack_d  = nack_q;
        rxack_d = rxack_q;
        start_d = 1'b0;
        wren_d  = wren_q;
        addr_d  = addr_q;
        din_d   = din_q;
`ifdef I2C_SEQ_TIMEOUT_EN
        poll_cnt_d   = poll_cnt_q;
        abort_d      = abort_q;
        poll_expired = (poll_cnt_q + 32'd1) >= POLL_LIMIT;
`endif

        acc_en   = 1'b0;
        acc_wren = 1'b1;
        acc_addr = 3'd0;
        acc_din  = 8'h00;
        case (state_q)
            INIT_PRL:  begin acc_en = 1'b1; acc_addr = 3'd0; acc_din = PRESCALE[7:0];  end
            INIT_PRH:  begin acc_en = 1'b1; acc_addr = 3'd1; acc_din = PRESCALE[15:8]; end
            INIT_CTR:  begin acc_en = 1'b1; acc_addr = 3'd2; acc_din = 8'h80;          end
            LD_TXR:    begin acc_en = 1'b1; acc_addr = 3'd3; acc_din = txr_val;        end
            WR_CR:     begin acc_en = 1'b1; acc_addr = 3'd4; acc_din = cr_val;         end
            STOP_CR:   begin acc_en = 1'b1; acc_addr = 3'd4; acc_din = 8'h40;          end
            POLL, STOP_POLL: begin
                acc_en   = 1'b1;
                acc_wren = 1'b0;
                acc_addr = 3'd4;
            end
            default: ;
        endcase

        acc_complete = acc_en && wait_q && ctl_done;

        if (acc_en && !wait_q) begin
            start_d = 1'b1;
            wren_d  = acc_wren;
            addr_d  = acc_addr;
            din_d   = acc_din;
            wait_d  = 1'b1;
        end
        if (acc_complete) begin
            wait_d = 1'b0;
        end

        case (state_q)
            INIT_PRL: if (acc_complete) state_d = INIT_PRH;
            INIT_PRH: if (acc_complete) state_d = INIT_CTR;
            INIT_CTR: if (acc_complete) state_d = IDLE;
            IDLE: begin
                if (req_valid) begin
                    dev_d   = req_dev;
                    reg_d   = req_reg;
                    data_d  = req_data;
                    nack_d  = 1'b0;
                    phase_d = 2'd0;
                    state_d = LD_TXR;
`ifdef I2C_SEQ_TIMEOUT_EN
                    abort_d = 1'b0;
`endif
                end
            end
            LD_TXR: if (acc_complete) state_d = WR_CR;
            WR_CR: begin
                if (acc_complete) begin
                    state_d = POLL;
`ifdef I2C_SEQ_TIMEOUT_EN
                    poll_cnt_d = 32'd0;
`endif
                end
            end
            POLL: begin
                if (acc_complete) begin
                    if (!ctl_dout[1]) begin
                        rxack_d = ctl_dout[7];
                        state_d = CHECK;
                    end
`ifdef I2C_SEQ_TIMEOUT_EN
                    else if (poll_expired) begin
                        nack_d  = 1'b1;
                        abort_d = 1'b1;
                        state_d = STOP_CR;
                    end else begin
                        poll_cnt_d = poll_cnt_q + 32'd1;
                    end
`endif
                end
            end
            CHECK: begin
                if (rxack_q) begin
                    nack_d  = 1'b1;
                    // The last phase already carries STO in its CR write.
                    state_d = (phase_q == 2'd2) ? FINISH : STOP_CR;
                end else if (phase_q == 2'd2) begin
                    state_d = FINISH;
                end else begin
                    phase_d = phase_q + 2'd1;
                    state_d = LD_TXR;
                end
            end
            STOP_CR: begin
                if (acc_complete) begin
`ifdef I2C_SEQ_TIMEOUT_EN
                    poll_cnt_d = 32'd0;
                    state_d    = abort_q ? FINISH : STOP_POLL;
`else
                    state_d = STOP_POLL;
`endif
                end
            end
            STOP_POLL: begin
                if (acc_complete) begin
                    if (!ctl_dout[1]) begin
                        state_d = FINISH;
                    end
`ifdef I2C_SEQ_TIMEOUT_EN
                    else if (poll_expired) begin
                        state_d = FINISH;
                    end else begin
                        poll_cnt_d = poll_cnt_q + 32'd1;
                    end
`endif
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = INIT_PRL;
        endcase
    end

    assign req_ready = (state_q == IDLE);
    assign done      = (state_q == FINISH);
    assign nack      = nack_q;
    assign ctl_start = start_q;
    assign ctl_wren  = wren_q;
    assign ctl_addr  = {29'd0, addr_q};
    assign ctl_din   = {24'd0, din_q};
    assign dbg_state = state_q;

endmodule

// File: tb/tb_i2c_write_sequencer.sv
// Testbench for i2c_write_sequencer: a randomised I2C-controller model answers
// accesses from a read-response queue, a reference model expands each request
// into its expected controller access list, and a monitor checks every
// strobe, hold, done pulse and nack against those queues.
module tb_i2c_write_sequencer;

  localparam int TO = 4;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [6:0]  req_dev;
  logic [7:0]  req_reg;
  logic [7:0]  req_data;
  logic [31:0] ctl_din;
  logic [31:0] ctl_addr;
  logic        ctl_start;
  logic        ctl_wren;
  logic [31:0] ctl_dout;
  logic        ctl_done;
  logic        done;
  logic        nack;
  logic [3:0]  dbg_state;

  i2c_write_sequencer #(.PRESCALE(16'h0020), .TIMEOUT_POLLS(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dev(req_dev), .req_reg(req_reg), .req_data(req_data),
    .ctl_din(ctl_din), .ctl_addr(ctl_addr), .ctl_start(ctl_start), .ctl_wren(ctl_wren),
    .ctl_dout(ctl_dout), .ctl_done(ctl_done),
    .done(done), .nack(nack), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [64:0] exp_acc_q[$];   // {wren, addr, din}; din ignored for reads
  logic [31:0] rd_q[$];        // SR values returned by the controller model
  logic [0:0]  exp_done_q[$];  // expected nack per finished request
  int n_vec = 0;
  int n_err = 0;
  int acc_seen = 0;

  task automatic check(input string name, input logic [64:0] got, input logic [64:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] sr_word(input bit tip, input bit rx);
    logic [31:0] v;
    v = $urandom;
    v[1] = tip;
    v[7] = rx;
    return v;
  endfunction

  task automatic push_wr(input int addr, input logic [7:0] d);
    exp_acc_q.push_back({1'b1, 32'(addr), 24'd0, d});
  endtask

  task automatic push_rd(input logic [31:0] sr);
    exp_acc_q.push_back({1'b0, 32'd4, 32'd0});
    rd_q.push_back(sr);
  endtask

  task automatic push_init();
    push_wr(0, 8'h20);
    push_wr(1, 8'h00);
    push_wr(2, 8'h80);
  endtask

  // nack_phase: 0 none, 1..3 RxACK=1 at that phase. stuck_phase: 0 none, else TIP never clears.
  task automatic push_request(input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] dat,
                              input int nack_phase, input int stuck_phase,
                              input int p0, input int p1, input int p2, input int sp);
    logic [7:0] txr[3];
    logic [7:0] cr[3];
    int polls[3];
    txr[0] = {dev, 1'b0}; txr[1] = rg; txr[2] = dat;
    cr[0] = 8'h90; cr[1] = 8'h10; cr[2] = 8'h50;
    polls[0] = p0; polls[1] = p1; polls[2] = p2;
    for (int p = 0; p < 3; p++) begin
      push_wr(3, txr[p]);
      push_wr(4, cr[p]);
      if (stuck_phase == p + 1) begin
        for (int i = 0; i < TO; i++) push_rd(sr_word(1'b1, 1'($urandom)));
        push_wr(4, 8'h40);
        exp_done_q.push_back(1'b1);
        return;
      end
      for (int i = 0; i < polls[p]; i++) push_rd(sr_word(1'b1, 1'($urandom)));
      push_rd(sr_word(1'b0, nack_phase == p + 1));
      if (nack_phase == p + 1) begin
        if (p < 2) begin
          push_wr(4, 8'h40);
          for (int i = 0; i < sp; i++) push_rd(sr_word(1'b1, 1'($urandom)));
          push_rd(sr_word(1'b0, 1'($urandom)));
        end
        exp_done_q.push_back(1'b1);
        return;
      end
    end
    exp_done_q.push_back(1'b0);
  endtask

  // ---------------- controller model ----------------
  bit pend;
  bit pend_rd;
  int lat;
  initial begin
    ctl_done = 1'b0;
    ctl_dout = 32'd0;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      ctl_done = 1'b0;
      if (!reset) begin
        pend = 1'b0;
      end else if (ctl_start) begin
        pend = 1'b1;
        pend_rd = !ctl_wren;
        lat = $urandom_range(1, 3);
      end else if (pend) begin
        lat--;
        if (lat == 0) begin
          pend = 1'b0;
          ctl_done = 1'b1;
          if (pend_rd) ctl_dout = (rd_q.size() > 0) ? rd_q.pop_front() : 32'd0;
          else ctl_dout = $urandom;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        // Stray completion with no access outstanding must be ignored.
        ctl_done = 1'b1;
        ctl_dout = $urandom;
      end
    end
  end

  // ---------------- monitor ----------------
  bit outst;
  bit done_prev;
  logic [64:0] held;
  logic [64:0] got;
  logic [64:0] exp;
  logic last_nack;
  initial begin
    outst = 1'b0;
    done_prev = 1'b0;
    last_nack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        outst = 1'b0;
        done_prev = 1'b0;
      end else begin
        got = {ctl_wren, ctl_addr, ctl_din};
        if (ctl_done) outst = 1'b0;
        if (ctl_start) begin
          check("single_outstanding", {64'd0, outst}, 65'd0);
          outst = 1'b1;
          held = got;
          acc_seen++;
          if (exp_acc_q.size() == 0) begin
            check("unexpected_access", got, 65'd0);
          end else begin
            exp = exp_acc_q.pop_front();
            if (exp[64]) check("write_access", got, exp);
            else check("read_access", {got[64:32], 32'd0}, {exp[64:32], 32'd0});
          end
        end else if (outst) begin
          check("access_hold", got, held);
        end
        if (done) begin
          check("ready_low_at_done", {64'd0, req_ready}, 65'd0);
          if (exp_done_q.size() == 0) begin
            check("unexpected_done", 65'd1, 65'd0);
          end else begin
            last_nack = exp_done_q.pop_front();
            check("done_nack", {64'd0, nack}, {64'd0, last_nack});
          end
          done_prev = 1'b1;
        end else if (done_prev) begin
          check("ready_after_done", {64'd0, req_ready}, 65'd1);
          check("nack_held", {64'd0, nack}, {64'd0, last_nack});
          done_prev = 1'b0;
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic issue_req(input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] dat,
                           input int nack_phase, input int stuck_phase,
                           input int p0, input int p1, input int p2, input int sp);
    int guard;
    req_dev = dev;
    req_reg = rg;
    req_data = dat;
    req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      check("req_accept_timeout", 65'd0, 65'd1);
      return;
    end
    push_request(dev, rg, dat, nack_phase, stuck_phase, p0, p1, p2, sp);
    @(negedge clk);
    check("busy_after_accept", {64'd0, req_ready}, 65'd0);
  endtask

  task automatic issue_random();
    int np;
    np = $urandom_range(0, 5);
    if (np > 3) np = 0;
    issue_req(7'($urandom), 8'($urandom), 8'($urandom), np, 0,
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_start"}, {64'd0, ctl_start}, 65'd0);
    check({tag, "_wren"},  {64'd0, ctl_wren}, 65'd0);
    check({tag, "_din"},   {33'd0, ctl_din}, 65'd0);
    check({tag, "_addr"},  {33'd0, ctl_addr}, 65'd0);
    check({tag, "_done"},  {64'd0, done}, 65'd0);
    check({tag, "_nack"},  {64'd0, nack}, 65'd0);
    check({tag, "_ready"}, {64'd0, req_ready}, 65'd0);
  endtask

  task automatic wait_init(input string tag);
    int guard;
    guard = 0;
    while (!req_ready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_ready"}, {64'd0, req_ready}, 65'd1);
    check({tag, "_writes_done"}, 65'(exp_acc_q.size()), 65'd0);
  endtask

  initial begin
    int target;
    int guard;
    reset = 1'b0;
    req_valid = 1'b0;
    req_dev = 7'd0;
    req_reg = 8'd0;
    req_data = 8'd0;
    repeat (4) @(negedge clk);
    check_reset_outputs("reset");

    // Init after reset release.
    push_init();
    reset = 1'b1;
    wait_init("init");

    // Good write with three TIP polls per phase, then address NACK.
    issue_req(7'h48, 8'h01, 8'hA5, 0, 0, 3, 3, 3, 0);
    req_valid = 1'b0;
    issue_req(7'h48, 8'h01, 8'hA5, 1, 0, 1, 0, 0, 2);

    // Back-to-back random requests with req_valid held throughout.
    for (int i = 0; i < 20; i++) issue_random();
    req_valid = 1'b0;

    // Reset during the phase-2 poll: p0=1 gives 4 accesses in phase 1,
    // then TXR, CR and the first SR read of phase 2.
    target = acc_seen;
    guard = 0;
    while (exp_done_q.size() != 0 && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    target = acc_seen;
    issue_req(7'h21, 8'h33, 8'h44, 0, 0, 1, 3, 0, 0);
    req_valid = 1'b0;
    target = target + 7;
    guard = 0;
    while (acc_seen < target && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    check("reached_phase2_poll", {64'd0, acc_seen >= target}, 65'd1);
    @(negedge clk);
    #2;
    reset = 1'b0;
    exp_acc_q.delete();
    rd_q.delete();
    exp_done_q.delete();
    repeat (3) begin
      @(negedge clk);
      check_reset_outputs("midreset");
    end
    push_init();
    reset = 1'b1;
    wait_init("reinit");
    issue_random();
    req_valid = 1'b0;

`ifdef I2C_SEQ_TIMEOUT_EN
    // TIP stuck in phase 2: TO status reads, then STO and nack.
    issue_req(7'h50, 8'h0F, 8'hC3, 0, 2, 0, 0, 0, 0);
    req_valid = 1'b0;
`endif

    guard = 0;
    while ((exp_done_q.size() != 0 || exp_acc_q.size() != 0) && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    repeat (4) @(negedge clk);
    check("drain_acc", 65'(exp_acc_q.size()), 65'd0);
    check("drain_done", 65'(exp_done_q.size()), 65'd0);
    check("drain_rd", 65'(rd_q.size()), 65'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/i2c_write_sequencer.md
I2C_WRITE_SEQUENCER -- requirements
Module: i2c_write_sequencer

Interface
REQ-001 SHALL have parameter PRESCALE, default 16'h0020: I2C clock prescale value loaded at init.
REQ-002 SHALL have parameter TIMEOUT_POLLS, default 1024: status-poll limit, used only when I2C_SEQ_TIMEOUT_EN is defined.
REQ-003 SHALL have port clk, input, 1, the single clock; every flop is on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port req_valid, input, 1, write request present.
REQ-006 SHALL have port req_ready, output, 1, sequencer idle and accepting.
REQ-007 SHALL have port req_dev, input, 7, 7-bit slave address.
REQ-008 SHALL have port req_reg, input, 8, slave register index.
REQ-009 SHALL have port req_data, input, 8, data byte.
REQ-010 SHALL have port ctl_din, output, 32, write data to the I2C controller.
REQ-011 SHALL have port ctl_addr, output, 32, controller register address.
REQ-012 SHALL have port ctl_start, output, 1, one-cycle access strobe.
REQ-013 SHALL have port ctl_wren, output, 1, 1 = write, 0 = read.
REQ-014 SHALL have port ctl_dout, input, 32, controller read data.
REQ-015 SHALL have port ctl_done, input, 1, controller access complete.
REQ-016 SHALL have port done, output, 1, one-cycle pulse when a request finishes.
REQ-017 SHALL have port nack, output, 1, error flag for the last request, valid with done and held until the next accept.

Function
REQ-018 SHALL perform each controller access as follows: ctl_start high for exactly 1 cycle; ctl_addr, ctl_din and ctl_wren driven that cycle and held until ctl_done; the next access issued no earlier than the cycle after ctl_done.
REQ-019 SHALL ignore ctl_done whenever no access is outstanding.
REQ-020 SHALL run the init sequence after reset, with req_ready=0 throughout: write addr 0 = PRESCALE[7:0], addr 1 = PRESCALE[15:8], addr 2 = 8'h80 (core enable).
REQ-021 SHALL, in IDLE, drive req_ready=1 and accept a request on the cycle req_valid && req_ready, latching req_dev, req_reg and req_data and clearing nack.
REQ-022 SHALL, after accept, run three byte phases, each writing TXR (addr 3), then CR (addr 4), then polling:
  - phase 1: TXR={dev,1'b0}, CR=8'h90 (STA|WR)
  - phase 2: TXR=reg, CR=8'h10 (WR)
  - phase 3: TXR=data, CR=8'h50 (STO|WR)
REQ-023 SHALL poll by reading SR (addr 4, ctl_wren=0) repeatedly until ctl_dout[1] (TIP) is 0.
REQ-024 SHALL then check ctl_dout[7] (RxACK); a value of 1 in phase 1 or 2 sets nack, writes CR=8'h40 (STO), polls until TIP=0, then finishes.
REQ-025 SHALL set nack if RxACK=1 in phase 3, with no extra STO write (STO is already issued).
REQ-026 SHALL pulse done for 1 cycle in FINISH and return to IDLE; req_ready rises the cycle after done.
REQ-027 SHALL implement the states INIT_PRL, INIT_PRH, INIT_CTR, IDLE, LD_TXR, WR_CR, POLL, CHECK, STOP_CR, STOP_POLL, FINISH, with an issue/wait sub-phase for each access.
REQ-028 SHALL hold req_ready=0 whenever not in IDLE, so req_valid while busy has no effect.
REQ-029 SHALL drive ctl_din[31:8]=0 and ctl_addr[31:3]=0 at all times.

Reset
REQ-030 SHALL, while reset=0, force ctl_start=0, ctl_wren=0, ctl_din=0, ctl_addr=0, done=0, nack=0, req_ready=0, and state=INIT_PRL.
REQ-031 SHALL, on reset assertion mid-request, abandon the request with no done pulse, then rerun init after release.

Configuration
REQ-032 SHALL, with I2C_SEQ_TIMEOUT_EN defined, count SR reads per poll loop; on reaching TIMEOUT_POLLS it sets nack, issues STO (CR=8'h40) without polling, and finishes.
REQ-033 SHALL, without I2C_SEQ_TIMEOUT_EN, have no poll counter and poll indefinitely.

Verification
REQ-034 SHALL verify init: release reset -> writes (0,8'h20), (1,8'h00), (2,8'h80) in order, then req_ready=1.
REQ-035 SHALL verify a good write: dev=7'h48, reg=8'h01, data=8'hA5, controller model ACKs after 3 TIP polls -> TXR writes 8'h90/8'h01/8'hA5, CR writes 90/10/50, done pulse with nack=0.
REQ-036 SHALL verify address NACK: RxACK=1 after phase 1 -> CR=8'h40 written, no TXR reg write, done with nack=1.
REQ-037 SHALL verify busy and back-to-back behaviour: req_valid held through a transfer -> exactly one accept per IDLE, and the second request starts the cycle after req_ready rises.
REQ-038 SHALL verify reset mid-poll: reset=0 during phase 2 -> all outputs zero, no done pulse, init sequence reissued.
REQ-039 SHALL verify timeout (with I2C_SEQ_TIMEOUT_EN, TIMEOUT_POLLS=4): TIP stuck at 1 -> 4 SR reads, CR=8'h40, done with nack=1.
